// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic bit depth_is_legal(input int depth);
        return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular entry store for the fetch queue: push at tail, pop at head, clear on flush.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  fetch_entry_t             i_wdata,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    fetch_entry_t  r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    always_comb begin
        w_pop  = i_pop && (r_count != '0);
        w_push = i_push && ((r_count != FULL) || w_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which slots are valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear && i_reset) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with credit-based request issue and redirect flush.
// Optional same-cycle bypass of responses into an empty queue: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall_D,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_vld,
    input  logic [31:0] i_imem_rdata,
    output logic        o_vld,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcplus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int UW = CW + 1;

    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two between 2 and 16");
    end

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_inflight;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_pcplus4;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_out;
    logic          w_fifo_vld;
    logic          w_resp_ok;
    logic          w_byp;
    logic          w_pop_t;
    logic          w_pop;
    logic          w_push;
    logic [UW-1:0] w_used;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_fifo_vld = (w_count != '0);
        // A response is only ours if a request went out last cycle and no flush is in progress.
        w_resp_ok  = i_reset && i_imem_vld && r_inflight && !i_redirect;
        w_wdata    = '{instr: i_imem_rdata, pc: r_req_pc};
        w_byp      = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        w_byp      = w_resp_ok && !w_fifo_vld;
`endif
        o_vld      = i_reset && (w_fifo_vld || w_byp);
        w_out      = w_byp ? w_wdata : w_head;

        o_instr    = r_hold_instr;
        o_pc       = r_hold_pc;
        o_pcplus4  = r_hold_pcplus4;
        if (o_vld) begin
            o_instr   = w_out.instr;
            o_pc      = w_out.pc;
            o_pcplus4 = w_out.pc + 32'd4;
        end

        w_pop_t = o_vld && !i_stall_D && !i_redirect;
        w_pop   = w_pop_t && w_fifo_vld;
        w_push  = w_resp_ok && !(w_byp && w_pop_t);

        // Slots already filled plus the one reserved by last cycle's request, less the one leaving.
        w_used      = UW'(w_count) + UW'(r_inflight) - UW'(w_pop_t);
        o_imem_req  = i_reset && (i_redirect || (w_used < UW'(DEPTH)));
        o_imem_addr = i_redirect ? i_redirect_pc : r_fetch_pc;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fetch_pc     <= RESET_PC;
            r_req_pc       <= '0;
            r_inflight     <= 1'b0;
            r_hold_instr   <= NOP_INSTR;
            r_hold_pc      <= '0;
            r_hold_pcplus4 <= '0;
        end else begin
            r_inflight <= o_imem_req;
            if (o_imem_req) begin
                r_req_pc   <= o_imem_addr;
                r_fetch_pc <= o_imem_addr + 32'd4;
            end
            if (o_vld) begin
                r_hold_instr   <= o_instr;
                r_hold_pc      <= o_pc;
                r_hold_pcplus4 <= o_pcplus4;
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_redirect),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; the memory model echoes the request address as data one cycle later.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall_D;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        mem_vld = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        o_vld;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pcplus4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall_D     (i_stall_D),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_vld    (mem_vld),
        .i_imem_rdata  (mem_rdata),
        .o_vld         (o_vld),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_pcplus4     (o_pcplus4)
    );

    always @(posedge clk) begin
        mem_vld   <= o_imem_req;
        mem_rdata <= o_imem_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        i_reset       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_stall_D     = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        hold_reset();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        i_stall_D     = 1'b1;
        repeat (2) step();
        vectors++; if (o_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %0h want 0", o_vld); end
        vectors++; if (o_imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0h want 0", o_imem_req); end
        vectors++; if (o_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_instr got %08h want 00000013", o_instr); end
        vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %08h want 0", o_pc); end
        vectors++; if (o_pcplus4 !== 32'h0) begin miscompares++; $display("FAIL reset_pcplus4 got %08h want 0", o_pcplus4); end
        i_redirect = 1'b0;
        i_stall_D  = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        hold_reset();
        i_reset = 1'b1;
        #1;
        vectors++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_req got req=%0h addr=%08h want 1/00000000", o_imem_req, o_imem_addr); end
        step();
        if (!BYP) begin
            vectors++; if (o_vld !== 1'b0) begin miscompares++; $display("FAIL fill_latency got vld=%0h want 0", o_vld); end
            step();
        end
        vectors++; if (o_vld !== 1'b1 || o_pc !== 32'h0) begin miscompares++; $display("FAIL first_valid got vld=%0h pc=%08h want 1/00000000", o_vld, o_pc); end
        for (int k = 1; k < 8; k++) begin
            step();
            exp_pc = 32'(k * 4);
            vectors++;
            if (o_vld !== 1'b1 || o_pc !== exp_pc || o_instr !== exp_pc || o_pcplus4 !== exp_pc + 32'd4) begin
                miscompares++;
                $display("FAIL stream_%0d got vld=%0h pc=%08h instr=%08h p4=%08h want pc=instr=%08h", k, o_vld, o_pc, o_instr, o_pcplus4, exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        int reqs;
        hold_reset();
        i_stall_D = 1'b1;
        i_reset   = 1'b1;
        #1;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_imem_req === 1'b1) reqs++;
            step();
        end
        vectors++; if (reqs != 4) begin miscompares++; $display("FAIL stall_req_count got %0d want 4", reqs); end
        vectors++; if (o_imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_full_req got %0h want 0", o_imem_req); end
        vectors++; if (o_vld !== 1'b1 || o_pc !== 32'h0) begin miscompares++; $display("FAIL stall_head got vld=%0h pc=%08h want 1/00000000", o_vld, o_pc); end
        i_stall_D = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (o_vld !== 1'b1 || o_pc !== 32'(k * 4)) begin
                miscompares++;
                $display("FAIL stall_drain_%0d got vld=%0h pc=%08h want 1/%08h", k, o_vld, o_pc, 32'(k * 4));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        hold_reset();
        i_stall_D = 1'b1;
        i_reset   = 1'b1;
        #1;
        repeat (4) step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        i_stall_D     = 1'b0;
        #1;
        vectors++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_req got req=%0h addr=%08h want 1/00000100", o_imem_req, o_imem_addr); end
        step();
        i_redirect = 1'b0;
        #1;
        if (!BYP) begin
            vectors++; if (o_vld !== 1'b0) begin miscompares++; $display("FAIL redir_flush got vld=%0h want 0", o_vld); end
        end
        for (int i = 0; i < 4 && o_vld !== 1'b1; i++) step();
        vectors++; if (o_vld !== 1'b1 || o_pc !== 32'h100 || o_instr !== 32'h100) begin miscompares++; $display("FAIL redir_target got vld=%0h pc=%08h instr=%08h want 1/00000100", o_vld, o_pc, o_instr); end
        step();
        vectors++; if (o_vld !== 1'b1 || o_pc !== 32'h104) begin miscompares++; $display("FAIL redir_next got vld=%0h pc=%08h want 1/00000104", o_vld, o_pc); end
    endtask

    task automatic test_redirect_discard();
        bit          seen8;
        bit          found;
        logic [31:0] first_pc;
        hold_reset();
        i_reset = 1'b1;
        #1;
        repeat (3) step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        #1;
        vectors++; if (o_imem_addr !== 32'h200) begin miscompares++; $display("FAIL discard_addr got %08h want 00000200", o_imem_addr); end
        step();
        i_redirect = 1'b0;
        #1;
        seen8    = 1'b0;
        found    = 1'b0;
        first_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (o_instr === 32'h8) seen8 = 1'b1;
            if (!found && o_vld === 1'b1) begin found = 1'b1; first_pc = o_pc; end
            step();
        end
        vectors++; if (seen8) begin miscompares++; $display("FAIL discard_resp got instr 00000008 at output want never"); end
        vectors++; if (!found || first_pc !== 32'h200) begin miscompares++; $display("FAIL discard_next got found=%0d pc=%08h want 1/00000200", found, first_pc); end
    endtask

    task automatic test_wrap();
        bit          found;
        logic [31:0] got_p4;
        hold_reset();
        i_reset = 1'b1;
        #1;
        repeat (2) step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        #1;
        vectors++; if (o_imem_addr !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_addr0 got %08h want fffffff8", o_imem_addr); end
        step();
        i_redirect = 1'b0;
        #1;
        vectors++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr1 got req=%0h addr=%08h want 1/fffffffc", o_imem_req, o_imem_addr); end
        step();
        vectors++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr2 got req=%0h addr=%08h want 1/00000000", o_imem_req, o_imem_addr); end
        found  = 1'b0;
        got_p4 = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            if (!found && o_vld === 1'b1 && o_pc === 32'hFFFF_FFFC) begin found = 1'b1; got_p4 = o_pcplus4; end
            step();
        end
        vectors++; if (!found || got_p4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pcplus4 got found=%0d p4=%08h want 1/00000000", found, got_p4); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_stall_D     = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_discard();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
